// File: rtl/mac_pe.sv
// Systolic multiply-accumulate processing element: double-buffered weights on a
// shift chain, two-stage data/partial-sum pipeline with optional saturation.
module mac_pe #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [WEIGHT_W-1:0] weight_in,
  output logic [WEIGHT_W-1:0] weight_out,
  input  logic                load_weight,
  input  logic                swap_weights,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  input  logic                data_valid_in,
  output logic                data_valid_out,
  input  logic [ACC_W-1:0]    acc_in,
  output logic [ACC_W-1:0]    acc_out,
  output logic                ovf,
  input  logic                clr_ovf
);

  localparam int PW = DATA_W + WEIGHT_W;

  logic [WEIGHT_W-1:0] wbuf0_q, wbuf0_d, wbuf1_q, wbuf1_d, wout_q, wout_d;
  logic                act_q, act_d;
  logic [WEIGHT_W-1:0] active_w, shadow_w;

  logic [DATA_W-1:0]   data_p1_q, data_p2_q;
  logic                vld_p1_q, vld_p2_q;
  logic [ACC_W-1:0]    acc_p1_q, acc_p2_q, acc_p2_d;
  logic [WEIGHT_W-1:0] w_p1_q;
  logic                ovf_q;

  logic [PW-1:0]       d_ext, w_ext, prod;
  logic [ACC_W-1:0]    prod_ext, mac_res;
  logic [ACC_W:0]      sum;
  logic                sum_ovf, ovf_set;

  function automatic logic ovf_detect(input logic [ACC_W-1:0] a,
                                      input logic [ACC_W-1:0] b,
                                      input logic [ACC_W:0]   s);
    if (SIGNED != 0)
      return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    else
      return s[ACC_W];
  endfunction

  // Negative overflow is only possible in signed mode when both addends are negative.
  function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W-1:0] s,
                                                input logic             ov,
                                                input logic             neg);
    if (!ov || SATURATE == 0) return s;
    if (SIGNED == 0) return '1;
    return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  assign active_w = act_q ? wbuf1_q : wbuf0_q;
  assign shadow_w = act_q ? wbuf0_q : wbuf1_q;

  always_comb begin
    wbuf0_d = wbuf0_q;
    wbuf1_d = wbuf1_q;
    wout_d  = wout_q;
    act_d   = act_q;
    if (load_weight) begin
      wout_d = shadow_w;
      if (act_q) wbuf0_d = weight_in;
      else       wbuf1_d = weight_in;
    end
    if (swap_weights) act_d = ~act_q;
  end

  // Stage 1 -> stage 2: multiply on width-extended operands, then add with carry out
  always_comb begin
    if (SIGNED != 0) begin
      d_ext = {{WEIGHT_W{data_p1_q[DATA_W-1]}}, data_p1_q};
      w_ext = {{DATA_W{w_p1_q[WEIGHT_W-1]}}, w_p1_q};
    end else begin
      d_ext = {{WEIGHT_W{1'b0}}, data_p1_q};
      w_ext = {{DATA_W{1'b0}}, w_p1_q};
    end
    prod = d_ext * w_ext;
    if (SIGNED != 0) prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    else             prod_ext = {{(ACC_W-PW){1'b0}}, prod};
    sum      = {1'b0, acc_p1_q} + {1'b0, prod_ext};
    sum_ovf  = ovf_detect(acc_p1_q, prod_ext, sum);
    mac_res  = saturate(sum[ACC_W-1:0], sum_ovf, prod_ext[ACC_W-1]);
    acc_p2_d = vld_p1_q ? mac_res : acc_p1_q;
    ovf_set  = vld_p1_q & sum_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf0_q   <= '0;
      wbuf1_q   <= '0;
      wout_q    <= '0;
      act_q     <= 1'b0;
      data_p1_q <= '0;
      vld_p1_q  <= 1'b0;
      acc_p1_q  <= '0;
      w_p1_q    <= '0;
      data_p2_q <= '0;
      vld_p2_q  <= 1'b0;
      acc_p2_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wbuf0_q <= wbuf0_d;
      wbuf1_q <= wbuf1_d;
      wout_q  <= wout_d;
      act_q   <= act_d;
      if (run) begin
        data_p1_q <= data_in;
        vld_p1_q  <= data_valid_in;
        acc_p1_q  <= acc_in;
        w_p1_q    <= active_w;
        data_p2_q <= data_p1_q;
        vld_p2_q  <= vld_p1_q;
        acc_p2_q  <= acc_p2_d;
      end
      if (run && ovf_set) ovf_q <= 1'b1;
      else if (clr_ovf)   ovf_q <= 1'b0;
    end
  end

  assign weight_out     = wout_q;
  assign data_out       = data_p2_q;
  assign data_valid_out = vld_p2_q;
  assign acc_out        = acc_p2_q;
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_mac_pe.sv
// Bench for mac_pe: three configurations (unsigned wrap 32b, signed saturate 16b,
// unsigned wrap 16b) driven in lockstep and compared against an integer model.
module tb_mac_pe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, load_weight, swap_weights, data_valid_in, clr_ovf;
  logic [7:0]  weight_in, data_in;
  logic [31:0] acc32_in;
  logic [15:0] acc16_in;

  logic [7:0]  wout0, wout1, wout2, dout0, dout1, dout2;
  logic        dv0, dv1, dv2, ovf0, ovf1, ovf2;
  logic [31:0] acc0;
  logic [15:0] acc1, acc2;

  int total = 0;
  int bad   = 0;

  mac_pe #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(32), .SIGNED(0), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst), .run(run), .weight_in(weight_in), .weight_out(wout0),
    .load_weight(load_weight), .swap_weights(swap_weights), .data_in(data_in),
    .data_out(dout0), .data_valid_in(data_valid_in), .data_valid_out(dv0),
    .acc_in(acc32_in), .acc_out(acc0), .ovf(ovf0), .clr_ovf(clr_ovf));

  mac_pe #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .run(run), .weight_in(weight_in), .weight_out(wout1),
    .load_weight(load_weight), .swap_weights(swap_weights), .data_in(data_in),
    .data_out(dout1), .data_valid_in(data_valid_in), .data_valid_out(dv1),
    .acc_in(acc16_in), .acc_out(acc1), .ovf(ovf1), .clr_ovf(clr_ovf));

  mac_pe #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(0)) u2 (
    .clk(clk), .rst(rst), .run(run), .weight_in(weight_in), .weight_out(wout2),
    .load_weight(load_weight), .swap_weights(swap_weights), .data_in(data_in),
    .data_out(dout2), .data_valid_in(data_valid_in), .data_valid_out(dv2),
    .acc_in(acc16_in), .acc_out(acc2), .ovf(ovf2), .clr_ovf(clr_ovf));

  // reference model state
  int     sgn_c [3] = '{0, 1, 0};
  int     sat_c [3] = '{0, 1, 0};
  int     aw_c  [3] = '{32, 16, 16};
  longint mw [2];
  int     mact;
  longint mwout;
  longint s1_d, s1_w, s1_acc32, s1_acc16;
  bit     s1_v;
  longint o_d;
  bit     o_v;
  longint o_acc [3];
  bit     o_ovf [3];

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact integer MAC, then range test against the accumulator format.
  function automatic void mac_ref(input longint w, input longint d, input longint acc,
                                  input int sgn, input int sat, input int aw,
                                  output longint res, output bit ov);
    longint ws, ds, as_, ex, lo, hi, mask;
    mask = (longint'(1) << aw) - 1;
    if (sgn != 0) begin
      ws  = (w >= 128) ? w - 256 : w;
      ds  = (d >= 128) ? d - 256 : d;
      as_ = (acc >= (longint'(1) << (aw-1))) ? acc - (longint'(1) << aw) : acc;
      lo  = -(longint'(1) << (aw-1));
      hi  = (longint'(1) << (aw-1)) - 1;
    end else begin
      ws = w; ds = d; as_ = acc; lo = 0; hi = mask;
    end
    ex = ws * ds + as_;
    ov = (ex < lo) || (ex > hi);
    if (ov && sat != 0) ex = (ex < lo) ? lo : hi;
    res = ex & mask;
  endfunction

  task automatic model_step();
    longint r, ain;
    bit     ov;
    if (rst) begin
      mw[0] = 0; mw[1] = 0; mact = 0; mwout = 0;
      s1_d = 0; s1_w = 0; s1_acc32 = 0; s1_acc16 = 0; s1_v = 0;
      o_d = 0; o_v = 0;
      for (int k = 0; k < 3; k++) begin o_acc[k] = 0; o_ovf[k] = 0; end
    end else begin
      for (int k = 0; k < 3; k++) begin
        ain = (k == 0) ? s1_acc32 : s1_acc16;
        mac_ref(s1_w, s1_d, ain, sgn_c[k], sat_c[k], aw_c[k], r, ov);
        if (run) o_acc[k] = s1_v ? r : ain;
        if (run && s1_v && ov) o_ovf[k] = 1;
        else if (clr_ovf)      o_ovf[k] = 0;
      end
      if (run) begin
        o_d = s1_d; o_v = s1_v;
        s1_d = data_in; s1_v = data_valid_in;
        s1_acc32 = acc32_in; s1_acc16 = acc16_in;
        s1_w = mw[mact];
      end
      if (load_weight) begin
        mwout = mw[1-mact];
        mw[1-mact] = weight_in;
      end
      if (swap_weights) mact = 1 - mact;
    end
  endtask

  task automatic check_all();
    chk_eq("u0.wout", wout0, mwout);  chk_eq("u1.wout", wout1, mwout);  chk_eq("u2.wout", wout2, mwout);
    chk_eq("u0.dout", dout0, o_d);    chk_eq("u1.dout", dout1, o_d);    chk_eq("u2.dout", dout2, o_d);
    chk_eq("u0.dv", dv0, o_v);        chk_eq("u1.dv", dv1, o_v);        chk_eq("u2.dv", dv2, o_v);
    chk_eq("u0.acc", acc0, o_acc[0]); chk_eq("u1.acc", acc1, o_acc[1]); chk_eq("u2.acc", acc2, o_acc[2]);
    chk_eq("u0.ovf", ovf0, o_ovf[0]); chk_eq("u1.ovf", ovf1, o_ovf[1]); chk_eq("u2.ovf", ovf2, o_ovf[2]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    rst = 0; run = 0; load_weight = 0; swap_weights = 0; clr_ovf = 0;
    data_valid_in = 0; weight_in = 0; data_in = 0; acc32_in = 0; acc16_in = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cyc(); rst = 0;
  endtask

  task automatic load_and_swap(input logic [7:0] w);
    load_weight = 1; weight_in = w; cyc();
    load_weight = 0; swap_weights = 1; cyc();
    swap_weights = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    cyc();
    chk_eq("rst_acc", acc0, 0);
    chk_eq("rst_ovf", ovf0, 0);
    rst = 0;

    // basic MAC: 3*5+10
    load_and_swap(8'd3);
    run = 1; data_in = 5; data_valid_in = 1; acc32_in = 10; acc16_in = 10; cyc();
    data_valid_in = 0; data_in = 0; cyc();
    chk_eq("basic_acc", acc0, 25);
    chk_eq("basic_dout", dout0, 5);
    chk_eq("basic_dv", dv0, 1);
    chk_eq("basic_acc_s", acc1, 25);

    // weight shift chain
    do_reset();
    load_weight = 1; weight_in = 7; cyc();
    chk_eq("chain_w0", wout0, 0);
    weight_in = 9; cyc();
    chk_eq("chain_w1", wout0, 7);
    load_weight = 0; swap_weights = 1; cyc();
    swap_weights = 0; run = 1; data_in = 1; data_valid_in = 1; acc32_in = 0; acc16_in = 0; cyc();
    data_valid_in = 0; cyc();
    chk_eq("chain_active9", acc0, 9);

    // swap mid-stream with a run=0 gap
    do_reset();
    load_and_swap(8'd2);
    load_weight = 1; weight_in = 4; cyc(); load_weight = 0;
    run = 1; data_in = 1; data_valid_in = 1; swap_weights = 1; cyc();
    swap_weights = 0; cyc();
    chk_eq("stream_1", acc0, 2);
    run = 0; cyc();
    chk_eq("stream_hold", acc0, 2);
    cyc();
    run = 1; cyc();
    chk_eq("stream_2", acc0, 4);
    data_valid_in = 0; cyc();
    chk_eq("stream_3", acc0, 4);

    // signed saturation at the negative limit
    do_reset();
    load_and_swap(8'h80);
    run = 1; data_in = 8'h7F; data_valid_in = 1; acc16_in = 16'h8000; cyc();
    data_valid_in = 0; cyc();
    chk_eq("sat_neg_acc", acc1, 16'h8000);
    chk_eq("sat_neg_ovf", ovf1, 1);
    run = 0; clr_ovf = 1; cyc(); clr_ovf = 0;
    chk_eq("clr_ovf", ovf1, 0);

    // unsigned wrap, then invalid pass-through
    do_reset();
    load_and_swap(8'd1);
    run = 1; data_in = 1; data_valid_in = 1; acc16_in = 16'hFFFF; cyc();
    data_valid_in = 0; cyc();
    chk_eq("wrap_acc", acc2, 0);
    chk_eq("wrap_ovf", ovf2, 1);
    cyc();
    chk_eq("pass_acc", acc2, 16'hFFFF);
    chk_eq("pass_ovf", ovf2, 1);

    // reset with a sample in flight
    do_reset();
    load_and_swap(8'd5);
    run = 1; data_in = 3; data_valid_in = 1; acc32_in = 1; acc16_in = 1; cyc();
    rst = 1; cyc(); rst = 0;
    chk_eq("midrst_acc", acc0, 0);
    chk_eq("midrst_dv", dv0, 0);
    chk_eq("midrst_wout", wout0, 0);
    data_in = 5; acc32_in = 77; acc16_in = 77; cyc();
    data_valid_in = 0; cyc();
    chk_eq("postrst_acc", acc0, 77);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      run           = ($urandom_range(0, 3) != 0);
      load_weight   = ($urandom_range(0, 3) == 0);
      swap_weights  = ($urandom_range(0, 5) == 0);
      clr_ovf       = ($urandom_range(0, 9) == 0);
      data_valid_in = 1'($urandom_range(0, 1));
      weight_in     = 8'($urandom);
      data_in       = 8'($urandom);
      acc32_in      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_0000 | 32'($urandom_range(0, 65535)))
                                                  : 32'($urandom);
      acc16_in      = 16'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
